branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/mips_core_pkg.sv | 73 +++++++
 rtl/btb_table.sv | 48 ++++
 rtl/branch_target_buffer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// mips_core_pkg
// Shared types and constants for the MIPS core front end.
// Contents:
//   ADDR_WIDTH         - width of program-counter / target addresses
//   BTB_INDEX_BITS     - default log2 entry count of the branch target buffer
//   BTB_TAG_WIDTH      - stored tag width, wide enough for any index size >= 0
//   BranchOutcome      - resolved branch direction
//   BtbEntry           - one branch target buffer entry
//   BtbWriteOp         - operation carried on the btb_table write port
//   BtbState           - sweep / normal-operation state of the BTB
//   btb_feedback_entry - next value of an entry given a resolved branch
package mips_core_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int BTB_INDEX_BITS = 6;
  // Tags are stored zero-extended to this width so the entry layout does
  // not depend on the INDEX_BITS parameter of a particular instance.
  localparam int BTB_TAG_WIDTH  = ADDR_WIDTH - 2;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_WIDTH-1:0] tag;
    logic [ADDR_WIDTH-1:0]    target;
    logic [1:0]               counter;
  } BtbEntry;

  typedef enum logic [1:0] {
    WR_NONE     = 2'd0,
    WR_CLEAR    = 2'd1,
    WR_FEEDBACK = 2'd2
  } BtbWriteOp;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } BtbState;

  // Hit: refresh target and step the 2-bit counter (jumps pin it to 3).
  // Miss: allocate on TAKEN or jump, replacing whatever alias lived there;
  // a not-taken conditional branch that misses leaves the entry untouched.
  function automatic BtbEntry btb_feedback_entry(
    input BtbEntry                  cur,
    input logic [BTB_TAG_WIDTH-1:0] tag,
    input logic [ADDR_WIDTH-1:0]    target,
    input BranchOutcome             outcome,
    input logic                     isJump
  );
    BtbEntry nxt;
    nxt = cur;
    if (cur.valid && (cur.tag == tag)) begin
      nxt.target = target;
      if (isJump) begin
        nxt.counter = 2'd3;
      end else if (outcome == TAKEN) begin
        if (cur.counter != 2'd3) nxt.counter = cur.counter + 2'd1;
      end else begin
        if (cur.counter != 2'd0) nxt.counter = cur.counter - 2'd1;
      end
    end else if ((outcome == TAKEN) || isJump) begin
      nxt.valid   = 1'b1;
      nxt.tag     = tag;
      nxt.target  = target;
      nxt.counter = isJump ? 2'd3 : 2'd2;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_table.sv
// btb_table
// Entry storage for the branch target buffer.
// Ports:
//   clk          - clock, writes on the rising edge
//   i_rd_idx     - combinational read index (fetch lookup)
//   o_rd_entry   - entry at i_rd_idx, reflecting contents before this edge
//   i_wr_op      - WR_NONE / WR_CLEAR (invalidate) / WR_FEEDBACK (update)
//   i_wr_idx     - entry written
//   i_wr_tag     - resolved tag (feedback only)
//   i_wr_target  - resolved target (feedback only)
//   i_wr_outcome - resolved direction (feedback only)
//   i_wr_is_jump - unconditional jump flag (feedback only)
// The feedback write is a read-modify-write of the addressed entry done
// inside the table, so one write port serves both sweep and update.
// The array has no reset; the sweep in the parent invalidates every entry.
module btb_table
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = BTB_INDEX_BITS
) (
  input  logic                     clk,
  input  logic [INDEX_BITS-1:0]    i_rd_idx,
  output BtbEntry                  o_rd_entry,
  input  BtbWriteOp                i_wr_op,
  input  logic [INDEX_BITS-1:0]    i_wr_idx,
  input  logic [BTB_TAG_WIDTH-1:0] i_wr_tag,
  input  logic [ADDR_WIDTH-1:0]    i_wr_target,
  input  BranchOutcome             i_wr_outcome,
  input  logic                     i_wr_is_jump
);

  localparam int ENTRIES = 2 ** INDEX_BITS;

  BtbEntry r_entries [ENTRIES];

  assign o_rd_entry = r_entries[i_rd_idx];

  always_ff @(posedge clk) begin
    case (i_wr_op)
      WR_CLEAR:    r_entries[i_wr_idx] <= '0;
      WR_FEEDBACK: r_entries[i_wr_idx] <= btb_feedback_entry(r_entries[i_wr_idx], i_wr_tag,
                                                             i_wr_target, i_wr_outcome,
                                                             i_wr_is_jump);
      default:     ;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   i_req_valid/i_req_pc - fetch lookup; o_req_hit/o_req_target/o_req_taken
//                          answer combinationally in the same cycle
//   o_busy               - invalidate sweep in progress (lookups miss,
//                          feedback ignored)
//   i_fb_*               - resolved branch/jump from EX, applied at the edge
//   i_flush              - restart the invalidate sweep from entry 0
//   o_lookup_count       - saturating count of accepted lookups
//   o_hit_count          - saturating count of hits
module branch_target_buffer
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = BTB_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_req_hit,
  output logic [ADDR_WIDTH-1:0] o_req_target,
  output logic                  o_req_taken,
  output logic                  o_busy,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic [ADDR_WIDTH-1:0] i_fb_target,
  input  BranchOutcome          i_fb_outcome,
  input  logic                  i_fb_is_jump,
  input  logic                  i_flush,
  output logic [31:0]           o_lookup_count,
  output logic [31:0]           o_hit_count
);

  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

  BtbState                  r_state;
  logic [INDEX_BITS-1:0]    r_sweepPtr;
  logic [31:0]              r_lookupCount;
  logic [31:0]              r_hitCount;

  logic                     w_busy;
  logic [INDEX_BITS-1:0]    w_reqIdx;
  logic [BTB_TAG_WIDTH-1:0] w_reqTag;
  logic [INDEX_BITS-1:0]    w_fbIdx;
  logic [BTB_TAG_WIDTH-1:0] w_fbTag;
  BtbEntry                  w_rdEntry;
  logic                     w_lookupEn;
  logic                     w_hit;
  BtbWriteOp                w_wrOp;
  logic [INDEX_BITS-1:0]    w_wrIdx;

  assign w_busy = (r_state == CLEAR);

  // index = pc[INDEX_BITS+1:2], tag = remaining upper bits (zero-extended)
  assign w_reqIdx = INDEX_BITS'(i_req_pc >> 2);
  assign w_reqTag = BTB_TAG_WIDTH'(i_req_pc >> (INDEX_BITS + 2));
  assign w_fbIdx  = INDEX_BITS'(i_fb_pc >> 2);
  assign w_fbTag  = BTB_TAG_WIDTH'(i_fb_pc >> (INDEX_BITS + 2));

  // rst_n gates the lookup as well, so outputs are quiet from the very
  // first reset cycle, before the state register has been loaded.
  assign w_lookupEn = i_req_valid & ~w_busy & rst_n;
  assign w_hit      = w_lookupEn & w_rdEntry.valid & (w_rdEntry.tag == w_reqTag);

  assign o_req_hit      = w_hit;
  assign o_req_target   = w_hit ? w_rdEntry.target : '0;
  assign o_req_taken    = w_hit & w_rdEntry.counter[1];
  assign o_busy         = w_busy;
  assign o_lookup_count = r_lookupCount;
  assign o_hit_count    = r_hitCount;

  // Shared write port: the sweep owns it whenever busy, which also makes
  // feedback arriving during a sweep a no-op.
  always_comb begin
    w_wrOp  = WR_NONE;
    w_wrIdx = w_fbIdx;
    if (w_busy) begin
      w_wrOp  = WR_CLEAR;
      w_wrIdx = r_sweepPtr;
    end else if (i_fb_valid && rst_n) begin
      w_wrOp  = WR_FEEDBACK;
    end
  end

  btb_table #(
    .INDEX_BITS (INDEX_BITS)
  ) u_table (
    .clk          (clk),
    .i_rd_idx     (w_reqIdx),
    .o_rd_entry   (w_rdEntry),
    .i_wr_op      (w_wrOp),
    .i_wr_idx     (w_wrIdx),
    .i_wr_tag     (w_fbTag),
    .i_wr_target  (i_fb_target),
    .i_wr_outcome (i_fb_outcome),
    .i_wr_is_jump (i_fb_is_jump)
  );

  // Sweep FSM: CLEAR walks every index once; a flush in either state
  // (re)starts the walk at entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_sweepPtr <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (i_flush) begin
            r_sweepPtr <= '0;
          end else if (r_sweepPtr == LAST_IDX) begin
            r_state    <= IDLE;
            r_sweepPtr <= '0;
          end else begin
            r_sweepPtr <= r_sweepPtr + INDEX_BITS'(1);
          end
        end
        IDLE: begin
          if (i_flush) begin
            r_state    <= CLEAR;
            r_sweepPtr <= '0;
          end
        end
        default: begin
          r_state    <= CLEAR;
          r_sweepPtr <= '0;
        end
      endcase
    end
  end

  // Statistics survive flushes and stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lookupCount <= '0;
      r_hitCount    <= '0;
    end else begin
      if (w_lookupEn && (r_lookupCount != 32'hFFFF_FFFF)) r_lookupCount <= r_lookupCount + 32'd1;
      if (w_hit && (r_hitCount != 32'hFFFF_FFFF))         r_hitCount    <= r_hitCount + 32'd1;
    end
  end

endmodule
